// File: rtl/noc_mesh_pkg.sv
// Shared constants and helpers for the 4x4 mesh network interface.
// Holds the datapath widths, the TX FSM state type and the logical-to-grid address map.
package noc_mesh_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned GRID_W = 6;
  localparam int unsigned MESH_N = 4;
  localparam int unsigned DEST_W = 4;

  typedef enum logic [1:0] {
    T_IDLE,
    T_SEND,
    T_GAP
  } tx_state_e;

  // The router grid carries a one-node halo ring, so interior node (row, col)
  // sits at (row+1, col+1) of a GRID_W-wide grid.
  function automatic logic [ADDR_W-1:0] logical_to_grid(input logic [DEST_W-1:0] d);
    int unsigned row;
    int unsigned col;
    row = int'(d) / MESH_N;
    col = int'(d) % MESH_N;
    return ADDR_W'((row + 1) * GRID_W + col + 1);
  endfunction

endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO, single clock, synchronous active-low reset.
// Ports:
//   i_clk, i_rst      clock, synchronous active-low reset
//   i_push, i_wdata   write request; ignored while full
//   i_pop             read request; ignored while empty
//   o_rdata           head entry (stable while empty, 0 after reset)
//   o_full, o_empty   occupancy flags
module noc_sync_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  // Push while empty is not bypassed: the new entry shows up after the edge.
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_rdata   = r_mem[r_rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end
  end

endmodule

// File: rtl/noc_net_iface_32b.sv
// Network interface between a processing element and the local port of one 4x4 mesh router node.
// TX path: PE flits are queued, mapped to grid addresses and handed to the router with a
//   valid/ack handshake; flits addressed to this node loop straight back into the RX queue.
// RX path: router flits addressed to this node are queued for the PE, others are dropped
//   and counted.
// Ports:
//   i_clk, i_rst                             clock, synchronous active-low reset
//   i_pe_tx_valid/o_pe_tx_ready/dest/data    PE transmit stream
//   o_pe_rx_valid/i_pe_rx_ready/o_pe_rx_data PE receive stream
//   o_out_addr/data/valid, i_from_out_ack    router input handshake
//   i_in_addr/data/valid, o_to_in_ack        router output handshake
//   o_drop_count                             saturating misaddressed-flit counter
module noc_net_iface_32b
  import noc_mesh_pkg::*;
#(
  parameter int unsigned ID       = 0,
  parameter int unsigned TX_DEPTH = 4,
  parameter int unsigned RX_DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pe_tx_valid,
  output logic              o_pe_tx_ready,
  input  logic [DEST_W-1:0] i_pe_tx_dest,
  input  logic [DATA_W-1:0] i_pe_tx_data,
  output logic              o_pe_rx_valid,
  input  logic              i_pe_rx_ready,
  output logic [DATA_W-1:0] o_pe_rx_data,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_valid,
  input  logic              i_from_out_ack,
  input  logic [ADDR_W-1:0] i_in_addr,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_to_in_ack,
  output logic [7:0]        o_drop_count
);

  localparam logic [DEST_W-1:0] MY_ID = DEST_W'(ID);
  localparam logic [ADDR_W-1:0] MY_G  = logical_to_grid(MY_ID);
  localparam int unsigned       TX_W  = DEST_W + DATA_W;

  tx_state_e r_state;

  logic [TX_W-1:0]   w_tx_wdata;
  logic [TX_W-1:0]   w_tx_rdata;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_tx_pop;
  logic [DEST_W-1:0] w_head_dest;
  logic [DATA_W-1:0] w_head_data;
  logic              w_head_local;

  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_rx_push;
  logic [DATA_W-1:0] w_rx_wdata;

  logic              w_addr_hit;
  logic              w_net_take;
  logic              w_net_wr;
  logic              w_launch;
  logic              w_loop;

  assign w_tx_wdata   = {i_pe_tx_dest, i_pe_tx_data};
  assign w_head_dest  = w_tx_rdata[TX_W-1:DATA_W];
  assign w_head_data  = w_tx_rdata[DATA_W-1:0];
  assign w_head_local = (w_head_dest == MY_ID);

  // Router side: ack spacing of one cycle lets the router retire the flit before we sample
  // in_valid again. A misaddressed flit needs no RX slot, so it is taken even when RX is full.
  assign w_addr_hit = (i_in_addr == MY_G);
  assign w_net_take = i_in_valid & ~o_to_in_ack & (~w_addr_hit | ~w_rx_full);
  assign w_net_wr   = w_net_take & w_addr_hit;

  // Loopback shares the RX write port; the network flit wins a same-cycle conflict.
  assign w_launch  = (r_state == T_IDLE) & ~w_tx_empty & ~w_head_local;
  assign w_loop    = (r_state == T_IDLE) & ~w_tx_empty & w_head_local & ~w_rx_full & ~w_net_wr;
  assign w_tx_pop  = w_launch | w_loop;

  assign w_rx_push  = w_net_wr | w_loop;
  assign w_rx_wdata = w_net_wr ? i_in_data : w_head_data;

  assign o_pe_tx_ready = ~w_tx_full;
  assign o_pe_rx_valid = ~w_rx_empty;

  noc_sync_fifo #(
    .DATA_W (TX_W),
    .DEPTH  (TX_DEPTH)
  ) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_pe_tx_valid),
    .i_wdata (w_tx_wdata),
    .i_pop   (w_tx_pop),
    .o_rdata (w_tx_rdata),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  noc_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_rx_push),
    .i_wdata (w_rx_wdata),
    .i_pop   (i_pe_rx_ready),
    .o_rdata (o_pe_rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  // TX FSM with registered router-facing outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= T_IDLE;
      o_out_valid <= 1'b0;
      o_out_addr  <= '0;
      o_out_data  <= '0;
    end else begin
      unique case (r_state)
        T_IDLE: begin
          if (w_launch) begin
            o_out_addr  <= logical_to_grid(w_head_dest);
            o_out_data  <= w_head_data;
            o_out_valid <= 1'b1;
            r_state     <= T_SEND;
          end
        end
        T_SEND: begin
          if (i_from_out_ack) begin
            o_out_valid <= 1'b0;
            r_state     <= T_GAP;
          end
        end
        T_GAP: begin
          // Gives the router a cycle to drop its ack before the next flit is offered.
          r_state <= T_IDLE;
        end
        default: begin
          r_state     <= T_IDLE;
          o_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_to_in_ack  <= 1'b0;
      o_drop_count <= '0;
    end else begin
      o_to_in_ack <= w_net_take;
      if (w_net_take && !w_addr_hit && o_drop_count != 8'hFF) begin
        o_drop_count <= o_drop_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_noc_net_iface_32b.sv
// Directed self-checking bench for noc_net_iface_32b instantiated as node ID=5 (grid address 14).
module tb_noc_net_iface_32b;

  logic        clk;
  logic        rst;
  logic        pe_tx_valid;
  logic        pe_tx_ready;
  logic [3:0]  pe_tx_dest;
  logic [31:0] pe_tx_data;
  logic        pe_rx_valid;
  logic        pe_rx_ready;
  logic [31:0] pe_rx_data;
  logic [7:0]  out_addr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        from_out_ack;
  logic [7:0]  in_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        to_in_ack;
  logic [7:0]  drop_count;

  int n_total;
  int n_bad;

  noc_net_iface_32b #(
    .ID       (5),
    .TX_DEPTH (4),
    .RX_DEPTH (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_pe_tx_valid  (pe_tx_valid),
    .o_pe_tx_ready  (pe_tx_ready),
    .i_pe_tx_dest   (pe_tx_dest),
    .i_pe_tx_data   (pe_tx_data),
    .o_pe_rx_valid  (pe_rx_valid),
    .i_pe_rx_ready  (pe_rx_ready),
    .o_pe_rx_data   (pe_rx_data),
    .o_out_addr     (out_addr),
    .o_out_data     (out_data),
    .o_out_valid    (out_valid),
    .i_from_out_ack (from_out_ack),
    .i_in_addr      (in_addr),
    .i_in_data      (in_data),
    .i_in_valid     (in_valid),
    .o_to_in_ack    (to_in_ack),
    .o_drop_count   (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a router-side flit, check it, then ack it for one cycle.
  task automatic tx_take(input string tag, input logic [7:0] want_addr,
                         input logic [31:0] want_data);
    int i;
    i = 0;
    while (!out_valid && i < 12) begin
      step();
      i++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_addr"}, {24'd0, out_addr}, {24'd0, want_addr});
    chk({tag, "_data"}, out_data, want_data);
    from_out_ack = 1'b1;
    step();
    from_out_ack = 1'b0;
    chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total      = 0;
    n_bad        = 0;
    rst          = 1'b0;
    pe_tx_valid  = 1'b0;
    pe_tx_dest   = '0;
    pe_tx_data   = '0;
    pe_rx_ready  = 1'b0;
    from_out_ack = 1'b0;
    in_addr      = '0;
    in_data      = '0;
    in_valid     = 1'b0;
    step();
    step();
    rst = 1'b1;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr", {24'd0, out_addr}, 32'd0);
    chk("rst_ack", {31'd0, to_in_ack}, 32'd0);
    chk("rst_drop", {24'd0, drop_count}, 32'd0);
    chk("rst_rx_valid", {31'd0, pe_rx_valid}, 32'd0);
    chk("rst_rx_data", pe_rx_data, 32'd0);
    chk("rst_tx_ready", {31'd0, pe_tx_ready}, 32'd1);

    // TX latency and hold: dest 10 -> grid (2+1)*6+2+1 = 21; ack two cycles after valid
    pe_tx_valid = 1'b1;
    pe_tx_dest  = 4'd10;
    pe_tx_data  = 32'hA5A5_0001;
    step();
    pe_tx_valid = 1'b0;
    chk("lat_early", {31'd0, out_valid}, 32'd0);
    step();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_addr", {24'd0, out_addr}, 32'd21);
    chk("lat_data", out_data, 32'hA5A5_0001);
    step();
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    from_out_ack = 1'b1;
    step();
    from_out_ack = 1'b0;
    chk("ack_drop", {31'd0, out_valid}, 32'd0);
    step();

    // Address map corners: 0->7, 15->28, 4->13
    pe_tx_valid = 1'b1;
    pe_tx_dest  = 4'd0;
    pe_tx_data  = 32'h0000_0A00;
    step();
    pe_tx_dest  = 4'd15;
    pe_tx_data  = 32'h0000_0A0F;
    step();
    pe_tx_dest  = 4'd4;
    pe_tx_data  = 32'h0000_0A04;
    step();
    pe_tx_valid = 1'b0;
    tx_take("map0", 8'd7, 32'h0000_0A00);
    tx_take("map15", 8'd28, 32'h0000_0A0F);
    tx_take("map4", 8'd13, 32'h0000_0A04);

    // RX to own address 14
    in_valid = 1'b1;
    in_addr  = 8'd14;
    in_data  = 32'h0000_1234;
    step();
    in_valid = 1'b0;
    chk("rx_ack", {31'd0, to_in_ack}, 32'd1);
    chk("rx_valid", {31'd0, pe_rx_valid}, 32'd1);
    chk("rx_data", pe_rx_data, 32'h0000_1234);
    step();
    chk("rx_ack_pulse", {31'd0, to_in_ack}, 32'd0);
    pe_rx_ready = 1'b1;
    step();
    pe_rx_ready = 1'b0;
    chk("rx_popped", {31'd0, pe_rx_valid}, 32'd0);

    // Misaddressed flit
    in_valid = 1'b1;
    in_addr  = 8'd15;
    in_data  = 32'h0000_DEAD;
    step();
    in_valid = 1'b0;
    chk("bad_ack", {31'd0, to_in_ack}, 32'd1);
    chk("bad_drop", {24'd0, drop_count}, 32'd1);
    chk("bad_no_rx", {31'd0, pe_rx_valid}, 32'd0);
    step();

    // Fill RX with four flits, fifth is back-pressured
    in_addr = 8'd14;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h100 + k;
      step();
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data  = 32'h105;
    step();
    chk("full_no_ack1", {31'd0, to_in_ack}, 32'd0);
    step();
    chk("full_no_ack2", {31'd0, to_in_ack}, 32'd0);
    pe_rx_ready = 1'b1;
    chk("full_head", pe_rx_data, 32'h100);
    step();
    pe_rx_ready = 1'b0;
    chk("pop_edge_no_ack", {31'd0, to_in_ack}, 32'd0);
    step();
    chk("after_pop_ack", {31'd0, to_in_ack}, 32'd1);
    in_valid = 1'b0;
    step();

    // Misaddressed flit is still taken while RX is full
    in_valid = 1'b1;
    in_addr  = 8'd3;
    step();
    in_valid = 1'b0;
    chk("full_bad_ack", {31'd0, to_in_ack}, 32'd1);
    chk("full_bad_drop", {24'd0, drop_count}, 32'd2);
    step();
    pe_rx_ready = 1'b1;
    chk("drain0", pe_rx_data, 32'h101);
    step();
    chk("drain1", pe_rx_data, 32'h102);
    step();
    chk("drain2", pe_rx_data, 32'h103);
    step();
    chk("drain3", pe_rx_data, 32'h105);
    step();
    pe_rx_ready = 1'b0;
    chk("drain_empty", {31'd0, pe_rx_valid}, 32'd0);

    // Loopback versus a same-cycle network write: network flit goes first
    pe_tx_valid = 1'b1;
    pe_tx_dest  = 4'd5;
    pe_tx_data  = 32'h0000_BEEF;
    step();
    pe_tx_valid = 1'b0;
    in_valid    = 1'b1;
    in_addr     = 8'd14;
    in_data     = 32'h0000_CAFE;
    step();
    in_valid = 1'b0;
    chk("lb_net_first", pe_rx_data, 32'h0000_CAFE);
    step();
    chk("lb_no_send", {31'd0, out_valid}, 32'd0);
    pe_rx_ready = 1'b1;
    chk("lb_head", pe_rx_data, 32'h0000_CAFE);
    step();
    chk("lb_second_valid", {31'd0, pe_rx_valid}, 32'd1);
    chk("lb_second", pe_rx_data, 32'h0000_BEEF);
    step();
    pe_rx_ready = 1'b0;
    chk("lb_empty", {31'd0, pe_rx_valid}, 32'd0);

    // TX back-pressure: five flits with no ack, then drain in order (dest 1 -> grid 8)
    pe_tx_dest = 4'd1;
    for (int k = 0; k < 5; k++) begin
      chk("fill_ready", {31'd0, pe_tx_ready}, 32'd1);
      pe_tx_valid = 1'b1;
      pe_tx_data  = 32'hF00 + k;
      step();
    end
    pe_tx_valid = 1'b0;
    chk("fill_full", {31'd0, pe_tx_ready}, 32'd0);
    tx_take("fill0", 8'd8, 32'hF00);
    tx_take("fill1", 8'd8, 32'hF01);
    tx_take("fill2", 8'd8, 32'hF02);
    tx_take("fill3", 8'd8, 32'hF03);
    tx_take("fill4", 8'd8, 32'hF04);

    // Reset while a flit is in T_SEND and an RX flit is buffered
    pe_tx_valid = 1'b1;
    pe_tx_dest  = 4'd2;
    pe_tx_data  = 32'h77;
    step();
    pe_tx_data = 32'h78;
    in_valid   = 1'b1;
    in_addr    = 8'd14;
    in_data    = 32'h99;
    step();
    pe_tx_valid = 1'b0;
    in_valid    = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_ack", {31'd0, to_in_ack}, 32'd1);
    chk("pre_rst_rx", {31'd0, pe_rx_valid}, 32'd1);
    rst = 1'b0;
    step();
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_ack", {31'd0, to_in_ack}, 32'd0);
    chk("mrst_rx", {31'd0, pe_rx_valid}, 32'd0);
    chk("mrst_ready", {31'd0, pe_tx_ready}, 32'd1);
    chk("mrst_drop", {24'd0, drop_count}, 32'd0);
    chk("mrst_rx_data", pe_rx_data, 32'd0);
    rst = 1'b1;
    step();
    step();
    step();
    chk("mrst_flushed", {31'd0, out_valid}, 32'd0);

    // Drop counter saturation: held in_valid is taken every other cycle
    in_valid = 1'b1;
    in_addr  = 8'd0;
    for (int k = 0; k < 508; k++) step();
    chk("sat_254", {24'd0, drop_count}, 32'd254);
    for (int k = 0; k < 4; k++) step();
    chk("sat_256_flits", {24'd0, drop_count}, 32'd255);
    for (int k = 0; k < 6; k++) step();
    chk("sat_hold", {24'd0, drop_count}, 32'd255);
    in_valid = 1'b0;
    chk("sat_no_rx", {31'd0, pe_rx_valid}, 32'd0);
    step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
